// File: rtl/scan_frame_ctrl.sv
// Row-scan timing and double-buffered 8x16 frame store
// for the LED matrix scan datapath.
module scan_frame_ctrl #(
    parameter int TICK_DIV  = 10000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [15:0] wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic [7:0]  row_sel,
    output logic [15:0] col_data,
    output logic [2:0]  slot,
    output logic        blank,
    output logic        frame_sync
);

    localparam logic [23:0] DIV_LAST  = 24'(TICK_DIV - 1);
    localparam logic [23:0] BLANK_END = 24'(BLANK_CYC);

    logic [23:0] div_q, div_d;
    logic [2:0]  slot_q, slot_d;
    logic        pend_q, pend_d;

    logic [15:0] front_q [8];
    logic [15:0] back_q  [8];

    logic [7:0]  row_sel_q;
    logic [15:0] col_q;
    logic [2:0]  slot_out_q;
    logic        blank_q;
    logic        sync_q;
    logic        ack_q;

    logic wrap;
    logic boundary;
    logic blank_now;
    logic accept;
    logic do_copy;

    assign wrap      = (div_q == DIV_LAST);
    assign boundary  = wrap && (slot_q == 3'd7);
    assign blank_now = (div_q < BLANK_END);
    assign accept    = wr_valid && !pend_q;
    assign do_copy   = boundary && pend_q;

    assign wr_ready   = !pend_q;
    assign swap_ack   = ack_q;
    assign row_sel    = row_sel_q;
    assign col_data   = col_q;
    assign slot       = slot_out_q;
    assign blank      = blank_q;
    assign frame_sync = sync_q;

    // Next-state for the slot divider and the pending-swap flag.
    // A request seen while a swap is already pending merges into it,
    // including one arriving on the boundary that performs the copy.
    always_comb begin
        div_d  = wrap ? 24'd0 : div_q + 24'd1;
        slot_d = wrap ? slot_q + 3'd1 : slot_q;
        pend_d = pend_q;
        if (do_copy) begin
            pend_d = 1'b0;
        end else if (swap_req) begin
            pend_d = 1'b1;
        end
    end

    // Divider, slot counter and swap-pending state.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= 24'd0;
            slot_q <= 3'd0;
            pend_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
            pend_q <= pend_d;
        end
    end

    // Back buffer takes writes only while no swap is pending,
    // so a copy never races a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                back_q[i] <= 16'd0;
            end
        end else if (accept) begin
            back_q[wr_row] <= wr_data;
        end
    end

    // Front buffer is replaced whole, only at a frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                front_q[i] <= 16'd0;
            end
        end else if (do_copy) begin
            for (int i = 0; i < 8; i++) begin
                front_q[i] <= back_q[i];
            end
        end
    end

    // Registered scan outputs decode the previous cycle's state.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_sel_q  <= 8'd0;
            col_q      <= 16'd0;
            slot_out_q <= 3'd0;
            blank_q    <= 1'b1;
            sync_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            row_sel_q  <= blank_now ? 8'd0 : (8'd1 << slot_q);
            col_q      <= blank_now ? 16'd0 : front_q[slot_q];
            slot_out_q <= slot_q;
            blank_q    <= blank_now;
            sync_q     <= boundary;
            ack_q      <= do_copy;
        end
    end

endmodule

// File: tb/tb_scan_frame_ctrl.sv
// Self-checking bench for scan_frame_ctrl: reset table, directed
// scenarios and randomized traffic against a cycle-count model.
module tb_scan_frame_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FR = 8 * TD;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic [7:0]  row_sel;
    logic [15:0] col_data;
    logic [2:0]  slot;
    logic        blank;
    logic        frame_sync;

    scan_frame_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clock      (clock),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .slot       (slot),
        .blank      (blank),
        .frame_sync (frame_sync)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position in the frame comes purely from the
    // number of cycles since reset; buffers are plain arrays.
    int          m_n;
    logic [15:0] m_front [8];
    logic [15:0] m_back  [8];
    bit          m_pend;

    logic [7:0]  e_row;
    logic [15:0] e_col;
    logic [2:0]  e_slot;
    logic        e_blank, e_fs, e_ack;

    int cyc_no;
    int ack_seen;
    int fs_seen;
    int fs_at;
    int col_nz;
    int ack_wo_fs;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h",
                     name, cyc_no, act, exp);
        end
    endtask

    function automatic void model_edge();
        int d;
        int s;
        if (reset) begin
            e_row = 8'd0; e_col = 16'd0; e_slot = 3'd0;
            e_blank = 1'b1; e_fs = 1'b0; e_ack = 1'b0;
            m_n = 0;
            m_pend = 0;
            for (int i = 0; i < 8; i++) begin
                m_front[i] = 16'd0;
                m_back[i] = 16'd0;
            end
            return;
        end
        d = m_n % TD;
        s = (m_n / TD) % 8;
        e_blank = (d < BC);
        e_row   = e_blank ? 8'd0 : 8'(1 << s);
        e_col   = e_blank ? 16'd0 : m_front[s];
        e_slot  = 3'(s);
        e_fs    = ((m_n % FR) == FR - 1);
        e_ack   = e_fs && m_pend;
        if (wr_valid && !m_pend) m_back[wr_row] = wr_data;
        if (e_ack) begin
            m_front = m_back;
            m_pend = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
        m_n++;
    endfunction

    // One clock: check ready before the edge, outputs after it.
    task automatic cyc();
        chk("wr_ready", wr_ready, !m_pend);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc_no++;
        chk("row_sel", row_sel, e_row);
        chk("col_data", col_data, e_col);
        chk("slot", slot, e_slot);
        chk("blank", blank, e_blank);
        chk("frame_sync", frame_sync, e_fs);
        chk("swap_ack", swap_ack, e_ack);
        if (swap_ack === 1'b1) ack_seen++;
        if (swap_ack === 1'b1 && frame_sync !== 1'b1) ack_wo_fs++;
        if (frame_sync === 1'b1) begin
            fs_seen++;
            fs_at = cyc_no;
        end
        if (col_data !== 16'd0) col_nz++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_cnt();
        ack_seen = 0; fs_seen = 0; fs_at = -1;
        col_nz = 0; ack_wo_fs = 0; cyc_no = 0;
    endtask

    typedef struct {
        logic        wv;
        logic [2:0]  wrow;
        logic [15:0] wdat;
        logic        sreq;
        logic        x_ready;
        logic [7:0]  x_row;
        logic [2:0]  x_slot;
        logic        x_blank;
    } vec_t;

    vec_t tbl [12];

    initial begin
        bit acc;

        tbl[0]  = '{0, 3'd0, 16'h0, 0, 1, 8'h00, 3'd0, 1};
        tbl[1]  = '{0, 3'd0, 16'h0, 0, 1, 8'h00, 3'd0, 1};
        tbl[2]  = '{1, 3'd4, 16'h1234, 0, 1, 8'h01, 3'd0, 0};
        tbl[3]  = '{1, 3'd4, 16'h5678, 0, 1, 8'h01, 3'd0, 0};
        tbl[4]  = '{0, 3'd0, 16'h0, 0, 1, 8'h01, 3'd0, 0};
        tbl[5]  = '{0, 3'd0, 16'h0, 0, 1, 8'h01, 3'd0, 0};
        tbl[6]  = '{0, 3'd0, 16'h0, 0, 1, 8'h01, 3'd0, 0};
        tbl[7]  = '{0, 3'd0, 16'h0, 0, 1, 8'h01, 3'd0, 0};
        tbl[8]  = '{0, 3'd0, 16'h0, 0, 1, 8'h00, 3'd1, 1};
        tbl[9]  = '{0, 3'd0, 16'h0, 0, 1, 8'h00, 3'd1, 1};
        tbl[10] = '{0, 3'd0, 16'h0, 0, 1, 8'h02, 3'd1, 0};
        tbl[11] = '{0, 3'd0, 16'h0, 0, 1, 8'h02, 3'd1, 0};

        reset = 1'b1; wr_valid = 1'b0; wr_row = 3'd0;
        wr_data = 16'd0; swap_req = 1'b0;
        m_pend = 0; m_n = 0;
        clr_cnt();
        repeat (2) @(posedge clock);
        model_edge();
        @(negedge clock);
        cyc();
        chk("rst_blank", blank, 1'b1);
        chk("rst_row", row_sel, 8'h00);
        chk("rst_ready", wr_ready, 1'b1);
        reset = 1'b0;

        // Scenario 1: scan timing straight out of reset
        clr_cnt();
        for (int i = 0; i < 12; i++) begin
            wr_valid = tbl[i].wv;
            wr_row   = tbl[i].wrow;
            wr_data  = tbl[i].wdat;
            swap_req = tbl[i].sreq;
            chk("tbl_ready", wr_ready, tbl[i].x_ready);
            cyc();
            chk("tbl_row", row_sel, tbl[i].x_row);
            chk("tbl_slot", slot, tbl[i].x_slot);
            chk("tbl_blank", blank, tbl[i].x_blank);
        end
        wr_valid = 1'b0;
        idle(70 - 12);
        chk("s1_fs_count", fs_seen, 1);
        chk("s1_fs_cycle", fs_at, FR);
        chk("s1_col_zero", col_nz, 0);

        // Scenario 2: fill the back buffer, no swap
        clr_cnt();
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_row = 3'(i);
            wr_data = 16'hA000 + 16'(i);
            chk("s2_ready", wr_ready, 1'b1);
            cyc();
        end
        wr_valid = 1'b0;
        idle(2 * FR);
        chk("s2_col_zero", col_nz, 0);
        chk("s2_no_ack", ack_seen, 0);

        // Scenario 3: swap request in slot 3
        for (int i = 0; i < FR && ((m_n / TD) % 8) != 3; i++) cyc();
        chk("s3_align", (m_n / TD) % 8, 3);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("s3_ready_low", wr_ready, 1'b0);
        clr_cnt();
        idle(FR + 8);
        chk("s3_ack_count", ack_seen, 1);
        chk("s3_ack_with_fs", ack_wo_fs, 0);
        chk("s3_ready_back", wr_ready, 1'b1);
        idle(FR);

        // Scenario 4: held write while a swap is pending
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        wr_valid = 1'b1; wr_row = 3'd2; wr_data = 16'hFFFF;
        acc = 0;
        for (int i = 0; i < 2 * FR && !acc; i++) begin
            acc = wr_ready;
            cyc();
        end
        wr_valid = 1'b0;
        chk("s4_accepted", acc, 1'b1);
        chk("s4_front2", m_front[2], 16'hA002);
        idle(FR);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        idle(2 * FR);
        chk("s4_front2_new", m_front[2], 16'hFFFF);

        // Scenario 5: swap request on the boundary cycle itself
        for (int i = 0; i < FR && (m_n % FR) != FR - 1; i++) cyc();
        chk("s5_pend_clear", wr_ready, 1'b1);
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        chk("s5_fs_now", frame_sync, 1'b1);
        chk("s5_no_ack_now", swap_ack, 1'b0);
        clr_cnt();
        idle(FR);
        chk("s5_ack_count", ack_seen, 1);
        chk("s5_ack_late", fs_at, FR);

        // Scenario 6: reset in slot 5 with a swap pending
        wr_valid = 1'b1; wr_row = 3'd5; wr_data = 16'h5A5A;
        cyc();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        for (int i = 0; i < FR && ((m_n / TD) % 8) != 5; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s6_ready", wr_ready, 1'b1);
        clr_cnt();
        idle(2 * FR + 8);
        chk("s6_no_ack", ack_seen, 0);
        chk("s6_col_zero", col_nz, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 99) < 30);
            wr_row = 3'($urandom_range(0, 7));
            wr_data = 16'($urandom);
            swap_req = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 999) < 2);
            cyc();
        end
        reset = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
